free_list: RTL and testbench
============================

# free_list

Physical-register free list for the out-of-order core's rename path. It answers Decode's allocate requests by presenting the next free physical register and popping it on `deq`. It accepts registers released by ROB commit and rolls back speculative allocations on flush. It sits between Decode/Rename (consumer), the ROB commit port (producer) and the global flush line.

## Interface
Parameters:
- `P_REG_NUM`, 64: number of physical registers. Power of two.
- `ARCH_REG_NUM`, 32: number of architectural registers. Depth of the list is `FL_DEPTH = P_REG_NUM - ARCH_REG_NUM`, a power of two.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `deq`  in  1  Decode consumes `deq_preg` this cycle.
- `deq_preg`  out  `$clog2(P_REG_NUM)`  next free physical register (head entry).
- `empty`  out  1  no free register available.
- `count`  out  `$clog2(FL_DEPTH)+1`  number of free entries.
- `enq`  in  1  ROB commit releases a register this cycle.
- `enq_preg`  in  `$clog2(P_REG_NUM)`  released register (the stale mapping of the committing rd).
- `commit_alloc`  in  1  committing instruction had rd≠0, i.e. it owns one allocation.
- `flush`  in  1  squash all uncommitted instructions.
- `overflow_err`  out  1  sticky; an `enq` was attempted while `count==FL_DEPTH`.

## Operation
- Storage is a circular buffer `mem[FL_DEPTH]`.
- Pointers `head`, `tail` and `commit_head` are each `$clog2(FL_DEPTH)+1` bits wide. The MSB is the wrap bit. Index = low bits.
- `count = tail - head` (modular, pointer width). `empty = (count==0)`.
- `deq_preg = mem[head]`, combinational. The value is undefined-but-stable when `empty`.
- Dequeue: when `deq && !empty && !flush`, `head <= head+1`. A `deq` while empty is ignored.
- Enqueue: when `enq && enq_preg!=0 && count!=FL_DEPTH`:
  - `mem[tail] <= enq_preg`
  - `tail <= tail+1`
  - `enq_preg==0` is dropped because p0 is hardwired zero.
- Commit tracking: `commit_alloc` causes `commit_head <= commit_head+1`.
- Flush:
  - `head <= commit_head_next`, where `commit_head_next` includes a same-cycle `commit_alloc`.
  - This returns every register allocated to a squashed instruction.
  - Those registers are still in `mem`, because `tail` cannot pass `commit_head`: live-register conservation guarantees `tail - commit_head <= FL_DEPTH`.
- Simultaneous events:
  - `deq` + `enq` when neither empty nor full: both take effect, and `count` is unchanged.
  - `deq` + `enq` while empty: `deq` is ignored (no bypass; see Configuration).
  - `flush` + `enq`: the enq is performed, because commit is older than the flush.
  - `flush` + `deq`: the deq is ignored.
  - `flush` + `commit_alloc`: handled as stated under Flush.
- Overflow: an `enq` while full is dropped and sets `overflow_err`. Only `rst` clears it.

## Timing
- Reset values:
  - `head=0`, `commit_head=0`, `tail={1'b1,0...}` (list full).
  - `mem[i]=ARCH_REG_NUM+i`.
  - Outputs: `deq_preg=ARCH_REG_NUM`, `empty=0`, `count=FL_DEPTH`, `overflow_err=0`.
- `rst` asserted mid-operation overrides all other inputs that cycle.
- All pointer and storage updates are visible on the next clock edge.
- `deq_preg`, `empty` and `count` are combinational from registered state only. They have no combinational path from `deq`, `enq` or `flush` (except in the bypass configuration).
- Registers freed by `enq` become dequeueable one cycle later.
- After `flush`, the restored `head` is visible the next cycle.
- Wrap-around: pointers increment modulo `2*FL_DEPTH`. Full/empty are distinguished by the wrap bit.

## Configuration
- `FREE_LIST_BYPASS_EN` defined:
  - When `empty && enq && enq_preg!=0 && !flush`, `empty` deasserts combinationally and `deq_preg=enq_preg`.
  - A same-cycle `deq` is honoured. `mem[tail]` is still written and both `head` and `tail` advance, so flush rollback remains exact.
  - This adds a combinational path from the ROB commit port to Decode.
- Not defined: the behaviour described above applies; an empty list stays empty for the cycle of an enqueue.

## Test plan
- Reset, then 32 consecutive `deq` → `deq_preg` = 32,33,…,63; `empty=1` after the 32nd; a 33rd `deq` leaves `count=0`.
- From empty, `enq` 40 → next cycle `empty=0`, `deq_preg=40`, `count=1`. `enq_preg=0` → `count` unchanged.
- Reset; `deq` ×3 (32,33,34); `commit_alloc` ×1; `flush` → next cycle `head=1`, `deq_preg=33`, `count=31`.
- `flush` with `commit_alloc` in the same cycle after `deq` ×3 → `deq_preg=33`.
- From full, `enq` 5 → dropped, `overflow_err=1`; `deq`+`enq` same cycle at `count=10` → `count` stays 10.
- Wrap: 100 cycles of alternating `deq`/`enq`, returning the dequeued value 3 cycles later → FIFO order is preserved across pointer wrap and `count` is never outside 29..32.

Source files
------------

// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list with flush rollback to the committed head
// Optional same-cycle enqueue-to-dequeue bypass: define FREE_LIST_BYPASS_EN.
module free_list #(
    parameter int P_REG_NUM    = 64,
    parameter int ARCH_REG_NUM = 32,
    localparam int FL_DEPTH    = P_REG_NUM - ARCH_REG_NUM,
    localparam int PW          = $clog2(P_REG_NUM),
    localparam int CW          = $clog2(FL_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          deq,
    output logic [PW-1:0] deq_preg,
    output logic          empty,
    output logic [CW-1:0] count,
    input  logic          enq,
    input  logic [PW-1:0] enq_preg,
    input  logic          commit_alloc,
    input  logic          flush,
    output logic          overflow_err
);
    localparam int IW = CW - 1;

    logic [PW-1:0] mem_q [FL_DEPTH];
    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] tail_q, tail_d;
    logic [CW-1:0] chead_q, chead_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] cnt;
    logic          full;
    logic          is_empty;
    logic          bypass;
    logic          deq_ok;
    logic          enq_ok;

    assign cnt      = tail_q - head_q;
    assign full     = (cnt == CW'(FL_DEPTH));
    assign is_empty = (cnt == '0);

`ifdef FREE_LIST_BYPASS_EN
    // Freshly released register is offered to Decode in the same cycle; it is
    // still written to mem so a later flush can rewind head across it.
    assign bypass = is_empty && enq && (enq_preg != '0) && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign deq_ok = deq && !flush && (!is_empty || bypass);
    assign enq_ok = enq && (enq_preg != '0) && !full;

    always_comb begin
        chead_d = chead_q + CW'(commit_alloc);
        tail_d  = tail_q + CW'(enq_ok);
        head_d  = flush ? chead_d : (head_q + CW'(deq_ok));
        ovf_d   = ovf_q | (enq & full);
    end

    assign count        = cnt;
    assign empty        = is_empty && !bypass;
    assign deq_preg     = bypass ? enq_preg : mem_q[head_q[IW-1:0]];
    assign overflow_err = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= CW'(FL_DEPTH);
            ovf_q   <= 1'b0;
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= PW'(ARCH_REG_NUM + i);
            end
        end else begin
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
            ovf_q   <= ovf_d;
            if (enq_ok) begin
                mem_q[tail_q[IW-1:0]] <= enq_preg;
            end
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - randomized and directed checks of free_list against a queue model
module tb_free_list;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       deq = 1'b0;
    logic [5:0] deq_preg;
    logic       empty;
    logic [5:0] count;
    logic       enq = 1'b0;
    logic [5:0] enq_preg = '0;
    logic       commit_alloc = 1'b0;
    logic       flush = 1'b0;
    logic       overflow_err;

    free_list dut (
        .clk(clk), .rst(rst), .deq(deq), .deq_preg(deq_preg), .empty(empty),
        .count(count), .enq(enq), .enq_preg(enq_preg), .commit_alloc(commit_alloc),
        .flush(flush), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Model: fl = free registers in dequeue order; spec = allocated, not yet committed.
    int fl[$];
    int spec[$];
    bit m_ovf;
    bit chk_en = 1'b0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        fl.delete();
        spec.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(32 + i);
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit e, input int ep, input bit c, input bit f);
        int pre;
        pre = fl.size();
        if (c && spec.size() > 0) void'(spec.pop_front());
        if (f) begin
            fl = {spec, fl};
            spec.delete();
        end else if (d && pre > 0) begin
            spec.push_back(fl.pop_front());
        end
        if (e) begin
            if (pre == DEPTH) m_ovf = 1'b1;
            else if (ep != 0) fl.push_back(ep);
        end
    endtask

    task automatic step(input bit r, input bit d, input bit e, input int ep, input bit c, input bit f);
        rst = r; deq = d; enq = e; enq_preg = 6'(ep); commit_alloc = c; flush = f;
        @(posedge clk);
        if (r) model_reset();
        else model_step(d, e, ep, c, f);
        @(negedge clk);
        rst = 1'b0; deq = 1'b0; enq = 1'b0; enq_preg = '0; commit_alloc = 1'b0; flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("count", int'(count), fl.size());
            check("empty", int'(empty), int'(fl.size() == 0));
            check("overflow_err", int'(overflow_err), int'(m_ovf));
            if (fl.size() > 0) check("deq_preg", int'(deq_preg), fl[0]);
        end
    end

    initial begin
        int held[$];
        int lo, hi, pre_spec;
        bit d, e, c, f;
        int ep;

        // Reset and drain the list
        step(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        check("rst_deq_preg", int'(deq_preg), 32);
        check("rst_count", int'(count), 32);
        check("rst_empty", int'(empty), 0);
        check("rst_ovf", int'(overflow_err), 0);
        for (int i = 0; i < 32; i++) begin
            check("drain_value", int'(deq_preg), 32 + i);
            step(0, 1, 0, 0, 0, 0);
        end
        check("drained_empty", int'(empty), 1);
        check("drained_count", int'(count), 0);
        step(0, 1, 0, 0, 0, 0);
        check("deq_when_empty_count", int'(count), 0);
        for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 1, 0);

        // Refill from empty
        step(0, 0, 1, 40, 0, 0);
        check("refill_empty", int'(empty), 0);
        check("refill_value", int'(deq_preg), 40);
        check("refill_count", int'(count), 1);
        step(0, 0, 1, 0, 0, 0);
        check("enq_p0_dropped", int'(count), 1);

        // Flush after a separate commit
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        check("flush_value", int'(deq_preg), 33);
        check("flush_count", int'(count), 31);

        // Flush with commit in the same cycle
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("flush_commit_value", int'(deq_preg), 33);
        check("flush_commit_count", int'(count), 31);

        // Overflow and simultaneous deq+enq
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 0, 0);
        check("ovf_set", int'(overflow_err), 1);
        check("ovf_count", int'(count), 32);
        for (int i = 0; i < 22; i++) step(0, 1, 0, 0, 1, 0);
        check("count_10", int'(count), 10);
        step(0, 1, 1, 7, 0, 0);
        check("deq_enq_count", int'(count), 10);
        check("ovf_sticky", int'(overflow_err), 1);
        step(1, 0, 0, 0, 0, 0);
        check("ovf_cleared", int'(overflow_err), 0);

        // Wrap: dequeue on even cycles, return each value 3 cycles later
        lo = 99; hi = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            d = (cyc % 2 == 0);
            e = (cyc % 2 == 1) && (held.size() > 0) && (cyc >= 3);
            ep = e ? held[0] : 0;
            if (e) void'(held.pop_front());
            if (d) held.push_back(int'(deq_preg));
            step(0, d, e, ep, e, 0);
            if (int'(count) < lo) lo = int'(count);
            if (int'(count) > hi) hi = int'(count);
        end
        check("wrap_count_min_ge29", int'(lo >= 29), 1);
        check("wrap_count_max_le32", int'(hi <= 32), 1);

        // Randomized traffic obeying live-register conservation
        step(1, 0, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(1, 0, 0, 0, 0, 0);
            end else begin
                d = ($urandom_range(0, 1) == 1);
                c = (spec.size() > 0) && ($urandom_range(0, 1) == 1);
                f = ($urandom_range(0, 19) == 0);
                pre_spec = spec.size() - int'(c);
                e = (fl.size() + pre_spec < DEPTH) && ($urandom_range(0, 2) != 0);
                ep = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 63));
                step(0, d, e, ep, c, f);
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
